// File: rtl/prefix_adder_pipe.sv
// rtl/prefix_adder_pipe.sv - pipelined Kogge-Stone adder/subtractor with valid/ready handshake
//
// Purpose: {cout,sum} = a_in + (sub ? ~b_in : b_in) + (sub ? 1 : cin), with signed overflow flag.
//   The bitwise (g,p) level plus log2(WIDTH) Kogge-Stone levels are spread over STAGES register
//   stages; the last register sits on the outputs. The whole pipeline stalls as one unit.
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   in_valid/in_ready         operand beat handshake (a_in, b_in, cin, sub)
//   out_valid/out_ready       result beat handshake (sum, cout, ovf)
module prefix_adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LOGW = $clog2(WIDTH);
  localparam int NLVL = LOGW + 1;

  // g/p: running group generate/propagate; hp: bitwise half-sum kept for the final xor;
  // ci: effective carry-in (needed as carry into bit 0).
  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] hp;
    logic             ci;
  } pfx_t;

  // Last level handled by stage k-1, i.e. ceil(k*NLVL/STAGES).
  function automatic int lvl_bound(int k);
    return (k * NLVL + STAGES - 1) / STAGES;
  endfunction

  // Applies levels lo+1..hi. Level 1 turns raw operands (a in g, effective b in p)
  // into bitwise g/p with the carry-in folded into bit 0; levels 2.. are Kogge-Stone.
  function automatic pfx_t apply_levels(pfx_t s_in, int lo, int hi);
    pfx_t s;
    pfx_t t;
    int   d;
    s = s_in;
    for (int j = 1; j <= NLVL; j++) begin
      if (j > lo && j <= hi) begin
        t = s;
        if (j == 1) begin
          t.hp   = s.g ^ s.p;
          t.p    = s.g ^ s.p;
          t.g    = s.g & s.p;
          t.g[0] = (s.g[0] & s.p[0]) | ((s.g[0] ^ s.p[0]) & s.ci);
        end else begin
          d = 1 << (j - 2);
          for (int i = 0; i < WIDTH; i++) begin
            if (i >= d) begin
              t.g[i] = s.g[i] | (s.p[i] & s.g[i-d]);
              t.p[i] = s.p[i] & s.p[i-d];
            end
          end
        end
        s = t;
      end
    end
    return s;
  endfunction

  // After all levels g[i] is the carry out of bit i. Returns {ovf, cout, sum}.
  function automatic logic [WIDTH+1:0] pack_result(pfx_t s);
    logic [WIDTH-1:0] c;
    c = {s.g[WIDTH-2:0], s.ci};
    return {s.g[WIDTH-2] ^ s.g[WIDTH-1], s.g[WIDTH-1], s.hp ^ c};
  endfunction

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  pfx_t             w_in;
  pfx_t             w_last;
  logic             w_last_vld;
  logic [WIDTH+1:0] w_res;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  assign w_b_eff  = sub ? ~b_in : b_in;
  assign w_in     = {a_in, w_b_eff, {WIDTH{1'b0}}, sub | cin};

  generate
    if (STAGES == 1) begin : g_comb
      assign w_last     = w_in;
      assign w_last_vld = in_valid;
    end else begin : g_pipe
      pfx_t r_st  [STAGES-1];
      logic r_vld [STAGES-1];
      pfx_t w_prev[STAGES-1];
      logic w_pv  [STAGES-1];
      pfx_t w_d   [STAGES-1];

      always_comb begin
        w_prev[0] = w_in;
        w_pv[0]   = in_valid;
        for (int s = 1; s < STAGES - 1; s++) begin
          w_prev[s] = r_st[s-1];
          w_pv[s]   = r_vld[s-1];
        end
        for (int s = 0; s < STAGES - 1; s++) begin
          w_d[s] = apply_levels(w_prev[s], lvl_bound(s), lvl_bound(s + 1));
        end
      end

      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          for (int s = 0; s < STAGES - 1; s++) begin
            r_vld[s] <= 1'b0;
            r_st[s]  <= '0;
          end
        end else if (w_adv) begin
          for (int s = 0; s < STAGES - 1; s++) begin
            r_vld[s] <= w_pv[s];
            if (w_pv[s]) r_st[s] <= w_d[s];
          end
        end
      end

      assign w_last     = r_st[STAGES-2];
      assign w_last_vld = r_vld[STAGES-2];
    end
  endgenerate

  assign w_res = pack_result(apply_levels(w_last, lvl_bound(STAGES - 1), NLVL));

  // Outputs only load on a valid beat so they stay put after a transfer.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (w_adv) begin
      out_valid <= w_last_vld;
      if (w_last_vld) {ovf, cout, sum} <= w_res;
    end
  end

endmodule
